// File: rtl/framebuffer_arbiter_pkg.sv
// Shared definitions for the frame-buffer arbiter: SPRAM geometry and the
// arbiter FSM encoding. The output stage derives its address width from
// FB_ADDR_W as well, so both ends always agree on the word-address width.
package framebuffer_arbiter_pkg;

  localparam int unsigned SPRAM_DEPTH  = 16384;
  localparam int unsigned SPRAM_WORD_W = 16;
  localparam int unsigned FB_ADDR_W    = $clog2(SPRAM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_ADDR    = 3'd1,
    ST_RD_CAPTURE = 3'd2,
    ST_HOLDOFF    = 3'd3,
    ST_WR         = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_side_t;

endpackage

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares the single-port pixel SPRAM between the host
// write path and the LED output stage read path, round-robin under contention.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   read_request             level request from the output stage
//   read_address             word to read, sampled on the grant cycle
//   read_data                returned word, valid with read_finished_strobe, held after
//   read_finished_strobe     one-cycle pulse per completed read
//   write_request            level request from the command decoder
//   write_address/data       target word and value, stable until write_ack
//   write_ack                one-cycle pulse when the write is committed
//   mem_address/data_in      SPRAM address and write data
//   mem_write_enable         SPRAM write enable
//   mem_data_out             SPRAM read data, one cycle after the address
module framebuffer_arbiter
  import framebuffer_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_BUS_WIDTH = FB_ADDR_W,
  parameter int unsigned READ_HOLDOFF      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read_request,
  input  logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  output logic [SPRAM_WORD_W-1:0]      read_data,
  output logic                         read_finished_strobe,
  input  logic                         write_request,
  input  logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  input  logic [SPRAM_WORD_W-1:0]      write_data,
  output logic                         write_ack,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
  output logic [SPRAM_WORD_W-1:0]      mem_data_in,
  output logic                         mem_write_enable,
  input  logic [SPRAM_WORD_W-1:0]      mem_data_out
);

  localparam int unsigned HOLD_W = (READ_HOLDOFF > 1) ? $clog2(READ_HOLDOFF + 1) : 1;

  arb_state_t                   state_q, state_d;
  grant_side_t                  last_grant_q, last_grant_d;
  logic [HOLD_W-1:0]            holdoff_cnt_q, holdoff_cnt_d;
  logic [SPRAM_WORD_W-1:0]      read_data_q, read_data_d;
  logic                         read_finished_strobe_q, read_finished_strobe_d;
  logic                         write_ack_q, write_ack_d;
  logic [ADDRESS_BUS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [SPRAM_WORD_W-1:0]      mem_data_in_q, mem_data_in_d;
  logic                         mem_write_enable_q, mem_write_enable_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                <= ST_IDLE;
      last_grant_q           <= GRANT_WRITE;
      holdoff_cnt_q          <= '0;
      read_data_q            <= '0;
      read_finished_strobe_q <= 1'b0;
      write_ack_q            <= 1'b0;
      mem_address_q          <= '0;
      mem_data_in_q          <= '0;
      mem_write_enable_q     <= 1'b0;
    end else begin
      state_q                <= state_d;
      last_grant_q           <= last_grant_d;
      holdoff_cnt_q          <= holdoff_cnt_d;
      read_data_q            <= read_data_d;
      read_finished_strobe_q <= read_finished_strobe_d;
      write_ack_q            <= write_ack_d;
      mem_address_q          <= mem_address_d;
      mem_data_in_q          <= mem_data_in_d;
      mem_write_enable_q     <= mem_write_enable_d;
    end
  end

  // Next-state and next-output logic. The memory-side signals are loaded at
  // grant time so they appear on the SPRAM in the access cycle itself.
  always_comb begin
    state_d                = state_q;
    last_grant_d           = last_grant_q;
    holdoff_cnt_d          = holdoff_cnt_q;
    read_data_d            = read_data_q;
    read_finished_strobe_d = 1'b0;
    write_ack_d            = 1'b0;
    mem_address_d          = mem_address_q;
    mem_data_in_d          = mem_data_in_q;
    mem_write_enable_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A read wins when it is alone or when the write side went last.
        if (read_request && (!write_request || (last_grant_q == GRANT_WRITE))) begin
          state_d       = ST_RD_ADDR;
          last_grant_d  = GRANT_READ;
          mem_address_d = read_address;
        end else if (write_request) begin
          state_d            = ST_WR;
          last_grant_d       = GRANT_WRITE;
          mem_address_d      = write_address;
          mem_data_in_d      = write_data;
          mem_write_enable_d = 1'b1;
          write_ack_d        = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        state_d                = ST_RD_CAPTURE;
        read_finished_strobe_d = 1'b1;
      end
      ST_RD_CAPTURE: begin
        read_data_d = mem_data_out;
        if (READ_HOLDOFF == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d       = ST_HOLDOFF;
          holdoff_cnt_d = HOLD_W'(READ_HOLDOFF);
        end
      end
      ST_HOLDOFF: begin
        // Gives the consumer FIFO time to update its full flag after the strobe.
        holdoff_cnt_d = holdoff_cnt_q - HOLD_W'(1);
        if (holdoff_cnt_q <= HOLD_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The SPRAM output register already holds the word in the strobe cycle, so
  // it is forwarded directly then; read_data_q keeps it for later cycles.
  assign read_data            = read_finished_strobe_q ? mem_data_out : read_data_q;
  assign read_finished_strobe = read_finished_strobe_q;
  assign write_ack            = write_ack_q;
  assign mem_address          = mem_address_q;
  assign mem_data_in          = mem_data_in_q;
  assign mem_write_enable     = mem_write_enable_q;

endmodule
